layer_sequencer: RTL and testbench

- Table-driven scheduler for the MobileNet MNIST-letters datapath. It replaces the hard-coded layer chain with a programmable descriptor list.
- Steps through up to NUM_LAYERS descriptors. Each layer goes through an optional weight-load handshake with the loader, then repeated start/stop passes of one engine (conv, maxp, dense or result).
- Drives engine enables, ping/pong picture-buffer bases, geometry (matrix, mem, filt) and globmaxp_en. Raises STOP when the list completes.

---
 rtl/layer_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_layer_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sequencer.sv
// Descriptor-table scheduler for the conv/maxp/dense/result engine chain.
// Walks layers, runs the optional weight-load handshake, then repeated engine passes.
module layer_sequencer #(
    parameter int SIZE_address_pix        = 13,
    parameter int NUM_LAYERS              = 16,
    parameter int picture_storage_limit   = 0,
    parameter int picture_storage_limit_2 = 3136
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        GO,
    input  logic                        cfg_we,
    input  logic [3:0]                  cfg_addr,
    input  logic [23:0]                 cfg_data,
    input  logic [3:0]                  cfg_last,
    input  logic [4:0]                  step,
    output logic                        nextstep,
    input  logic                        STOP_conv,
    input  logic                        STOP_maxp,
    input  logic                        STOP_dense,
    input  logic                        STOP_res,
    output logic                        conv_en,
    output logic                        maxp_en,
    output logic                        dense_en,
    output logic                        result_en,
    output logic [SIZE_address_pix-1:0] memstartp,
    output logic [SIZE_address_pix-1:0] memstartzap,
    output logic [4:0]                  matrix,
    output logic [4:0]                  mem,
    output logic [4:0]                  filt,
    output logic                        globmaxp_en,
    output logic [3:0]                  pass_idx,
    output logic [3:0]                  layer_idx,
    output logic                        busy,
    output logic                        STOP
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WLOAD, S_ARM, S_RUN, S_GAP, S_NEXT, S_DONE
    } state_t;

    localparam logic [SIZE_address_pix-1:0] PING =
        SIZE_address_pix'(picture_storage_limit);
    localparam logic [SIZE_address_pix-1:0] PONG =
        SIZE_address_pix'(picture_storage_limit_2);

    state_t      state;
    logic [23:0] tbl [NUM_LAYERS];
    logic [23:0] desc;
    logic [3:0]  last_q;
    logic [4:0]  s0;
    logic        wl_first;
    logic [1:0]  op_q;
    logic        glob_q;
    logic [3:0]  reps_q;
    logic [3:0]  en;
    logic        sel_stop;
    logic        cfg_open;

    assign cfg_open = (state == S_IDLE) || (state == S_DONE);
    assign busy     = !cfg_open;
    assign desc     = tbl[layer_idx];

    assign conv_en   = en[0];
    assign maxp_en   = en[1];
    assign dense_en  = en[2];
    assign result_en = en[3];

    assign globmaxp_en = glob_q && (pass_idx == reps_q);

    // Table RAM carries no reset so a reload is not needed after rst_n.
    always_ff @(posedge clk) begin
        if (cfg_we && cfg_open)
            tbl[cfg_addr] <= cfg_data;
    end

    always_comb begin
        sel_stop = 1'b0;
        unique case (op_q)
            2'd0: sel_stop = STOP_conv;
            2'd1: sel_stop = STOP_maxp;
            2'd2: sel_stop = STOP_dense;
            2'd3: sel_stop = STOP_res;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            last_q      <= '0;
            s0          <= '0;
            wl_first    <= 1'b0;
            op_q        <= '0;
            glob_q      <= 1'b0;
            reps_q      <= '0;
            en          <= '0;
            nextstep    <= 1'b0;
            memstartp   <= '0;
            memstartzap <= '0;
            matrix      <= '0;
            mem         <= '0;
            filt        <= '0;
            pass_idx    <= '0;
            layer_idx   <= '0;
            STOP        <= 1'b0;
        end else begin
            nextstep <= 1'b0;
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (GO) begin
                        last_q    <= cfg_last;
                        layer_idx <= '0;
                        STOP      <= 1'b0;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    op_q     <= desc[1:0];
                    glob_q   <= desc[4];
                    matrix   <= desc[9:5];
                    mem      <= desc[14:10];
                    filt     <= desc[19:15];
                    reps_q   <= desc[23:20];
                    pass_idx <= '0;
                    if (desc[3]) begin
                        memstartp   <= PONG;
                        memstartzap <= PING;
                    end else begin
                        memstartp   <= PING;
                        memstartzap <= PONG;
                    end
                    if (desc[2]) begin
                        nextstep <= 1'b1;
                        wl_first <= 1'b1;
                        state    <= S_WLOAD;
                    end else begin
                        state <= S_ARM;
                    end
                end
                S_WLOAD: begin
                    // Loader acknowledges by advancing step twice.
                    if (wl_first) begin
                        s0       <= step;
                        wl_first <= 1'b0;
                    end else if (step == s0 + 5'd2) begin
                        state <= S_ARM;
                    end
                end
                S_ARM: begin
                    if (!sel_stop) begin
                        en    <= 4'b0001 << op_q;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (sel_stop) begin
                        en    <= '0;
                        state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (pass_idx < reps_q) begin
                        pass_idx <= pass_idx + 4'd1;
                        state    <= S_ARM;
                    end else begin
                        state <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (layer_idx == last_q) begin
                        STOP  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        layer_idx <= layer_idx + 4'd1;
                        state     <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Bench for layer_sequencer: scoreboard of expected enable rises
// plus directed checks of handshake, stale STOP and reset behaviour.
module tb_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        GO = 1'b0;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [23:0] cfg_data = '0;
    logic [3:0]  cfg_last = '0;
    logic [4:0]  step = '0;
    logic        nextstep;
    logic        STOP_conv, STOP_maxp, STOP_dense, STOP_res;
    logic        conv_en, maxp_en, dense_en, result_en;
    logic [12:0] memstartp, memstartzap;
    logic [4:0]  matrix, mem, filt;
    logic        globmaxp_en;
    logic [3:0]  pass_idx, layer_idx;
    logic        busy, STOP;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0]  en;
        logic [3:0]  layer;
        logic [3:0]  pass;
        logic [12:0] p;
        logic [12:0] z;
        logic [4:0]  m;
        logic        g;
    } ev_t;

    ev_t exp_q[$];

    layer_sequencer dut (
        .clk(clk), .rst_n(rst_n), .GO(GO),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_last(cfg_last), .step(step), .nextstep(nextstep),
        .STOP_conv(STOP_conv), .STOP_maxp(STOP_maxp),
        .STOP_dense(STOP_dense), .STOP_res(STOP_res),
        .conv_en(conv_en), .maxp_en(maxp_en),
        .dense_en(dense_en), .result_en(result_en),
        .memstartp(memstartp), .memstartzap(memstartzap),
        .matrix(matrix), .mem(mem), .filt(filt),
        .globmaxp_en(globmaxp_en), .pass_idx(pass_idx),
        .layer_idx(layer_idx), .busy(busy), .STOP(STOP)
    );

    always #5 clk = ~clk;

    // Engine models: STOP is a delayed copy of the engine's enable.
    logic [3:0] conv_sr = '0;
    logic [1:0] maxp_sr = '0;
    logic [1:0] dense_sr = '0;
    logic [1:0] res_sr = '0;
    logic       dense_hold = 1'b0;

    always @(posedge clk) begin
        conv_sr  <= {conv_sr[2:0], conv_en};
        maxp_sr  <= {maxp_sr[0], maxp_en};
        dense_sr <= {dense_sr[0], dense_en};
        res_sr   <= {res_sr[0], result_en};
    end

    assign STOP_conv  = conv_sr[3];
    assign STOP_maxp  = maxp_sr[1];
    assign STOP_dense = dense_sr[1] | dense_hold;
    assign STOP_res   = res_sr[1];

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ev_t ev(input logic [3:0] e, input logic [3:0] l,
                               input logic [3:0] ps, input logic [12:0] p,
                               input logic [12:0] z, input logic [4:0] m,
                               input logic g);
        ev_t r;
        r.en = e; r.layer = l; r.pass = ps;
        r.p = p; r.z = z; r.m = m; r.g = g;
        return r;
    endfunction

    function automatic logic [23:0] dsc(input logic [1:0] op, input logic wl,
                                        input logic src, input logic g,
                                        input logic [4:0] m, input logic [4:0] mm,
                                        input logic [4:0] f, input logic [3:0] r);
        return {r, f, mm, m, g, src, wl, op};
    endfunction

    task automatic write_desc(input logic [3:0] a, input logic [23:0] d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic go(input logic [3:0] last);
        @(negedge clk);
        GO = 1'b1; cfg_last = last;
        @(negedge clk);
        GO = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (STOP !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_reached", 64'(STOP), 64'(1));
        check("busy_low", 64'(busy), 64'(0));
        check("sb_empty", 64'(exp_q.size()), 64'(0));
    endtask

    task automatic wait_conv(input int budget);
        int n = 0;
        while (conv_en !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("conv_en_seen", 64'(conv_en), 64'(1));
    endtask

    // Monitor: every enable rise must match the next scoreboard entry.
    initial begin
        logic [3:0] prev;
        logic [3:0] cur;
        ev_t        o;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {result_en, dense_en, maxp_en, conv_en};
            if (!rst_n) begin
                prev = '0;
            end else begin
                check("onehot_en", 64'($onehot0(cur)), 64'(1));
                if ((cur & ~prev) != 4'd0) begin
                    o = ev(cur, layer_idx, pass_idx, memstartp,
                           memstartzap, matrix, globmaxp_en);
                    check("sb_nonempty", 64'(exp_q.size() != 0), 64'(1));
                    if (exp_q.size() != 0)
                        check("en_rise", 64'(o), 64'(exp_q.pop_front()));
                end
                prev = cur;
            end
        end
    end

    initial begin
        int  ns;
        logic seen;

        repeat (3) @(negedge clk);
        check("reset_ctl", 64'({conv_en, maxp_en, dense_en, result_en,
                                nextstep, globmaxp_en, busy, STOP,
                                pass_idx, layer_idx}), 64'(0));
        check("reset_geo", 64'({memstartp, memstartzap, matrix, mem, filt}),
              64'(0));
        rst_n = 1'b1;

        // Single conv layer, three passes
        write_desc(4'd0, dsc(2'd0, 1'b0, 1'b0, 1'b0, 5'd28, 5'd4, 5'd3, 4'd2));
        for (int i = 0; i < 3; i++)
            exp_q.push_back(ev(4'b0001, 4'd0, 4'(i), 13'd0, 13'd3136, 5'd28, 1'b0));
        go(4'd0);
        wait_done(200);
        check("geo_hold", 64'({matrix, mem, filt}), 64'({5'd28, 5'd4, 5'd3}));

        // Weight-load layer
        step = 5'd3;
        write_desc(4'd0, dsc(2'd0, 1'b1, 1'b0, 1'b0, 5'd14, 5'd2, 5'd1, 4'd0));
        exp_q.push_back(ev(4'b0001, 4'd0, 4'd0, 13'd0, 13'd3136, 5'd14, 1'b0));
        go(4'd0);
        ns = 0;
        seen = 1'b0;
        @(negedge clk);
        ns += int'(nextstep);
        @(negedge clk);
        ns += int'(nextstep);
        step = 5'd4;
        repeat (4) begin
            @(negedge clk);
            ns += int'(nextstep);
            seen |= conv_en;
        end
        check("nextstep_pulses", 64'(ns), 64'(1));
        check("no_en_in_wload", 64'(seen), 64'(0));
        step = 5'd5;
        @(negedge clk);
        check("wload_arm_gap", 64'(conv_en), 64'(0));
        @(negedge clk);
        check("wload_en_rise", 64'(conv_en), 64'(1));
        wait_done(200);

        // Two layers: maxp from pong, then result from ping
        write_desc(4'd0, dsc(2'd1, 1'b0, 1'b1, 1'b0, 5'd14, 5'd6, 5'd2, 4'd0));
        write_desc(4'd1, dsc(2'd3, 1'b0, 1'b0, 1'b0, 5'd7, 5'd8, 5'd5, 4'd0));
        exp_q.push_back(ev(4'b0010, 4'd0, 4'd0, 13'd3136, 13'd0, 5'd14, 1'b0));
        exp_q.push_back(ev(4'b1000, 4'd1, 4'd0, 13'd0, 13'd3136, 5'd7, 1'b0));
        go(4'd1);
        wait_done(200);
        check("last_layer_idx", 64'(layer_idx), 64'(1));

        // Stale dense STOP holds the sequencer in ARM
        write_desc(4'd0, dsc(2'd2, 1'b0, 1'b0, 1'b0, 5'd10, 5'd1, 5'd9, 4'd0));
        exp_q.push_back(ev(4'b0100, 4'd0, 4'd0, 13'd0, 13'd3136, 5'd10, 1'b0));
        dense_hold = 1'b1;
        go(4'd0);
        repeat (5) @(negedge clk);
        check("stale_no_en", 64'(dense_en), 64'(0));
        check("stale_busy", 64'(busy), 64'(1));
        dense_hold = 1'b0;
        @(negedge clk);
        check("stale_en_rise", 64'(dense_en), 64'(1));
        wait_done(200);

        // Reset while RUN, with a blocked table write
        write_desc(4'd0, dsc(2'd0, 1'b0, 1'b0, 1'b0, 5'd20, 5'd3, 5'd3, 4'd3));
        exp_q.push_back(ev(4'b0001, 4'd0, 4'd0, 13'd0, 13'd3136, 5'd20, 1'b0));
        go(4'd0);
        wait_conv(50);
        cfg_we = 1'b1;
        cfg_addr = 4'd0;
        cfg_data = dsc(2'd1, 1'b0, 1'b1, 1'b0, 5'd9, 5'd9, 5'd9, 4'd0);
        @(negedge clk);
        cfg_we = 1'b0;
        check("run_before_rst", 64'(conv_en), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async_en_drop", 64'(conv_en), 64'(0));
        check("rst_busy", 64'({busy, STOP, layer_idx, pass_idx}), 64'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++)
            exp_q.push_back(ev(4'b0001, 4'd0, 4'(i), 13'd0, 13'd3136, 5'd20, 1'b0));
        go(4'd0);
        wait_done(300);

        // globmaxp qualified on the final pass; GO during RUN ignored
        write_desc(4'd0, dsc(2'd0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd5, 4'd1));
        exp_q.push_back(ev(4'b0001, 4'd0, 4'd0, 13'd0, 13'd3136, 5'd5, 1'b0));
        exp_q.push_back(ev(4'b0001, 4'd0, 4'd1, 13'd0, 13'd3136, 5'd5, 1'b1));
        go(4'd0);
        wait_conv(50);
        GO = 1'b1;
        @(negedge clk);
        GO = 1'b0;
        check("go_in_run", 64'({busy, conv_en, pass_idx}), 64'({1'b1, 1'b1, 4'd0}));
        wait_done(200);
        check("glob_final", 64'(globmaxp_en), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
